// File: rtl/pwm_ctrl.sv
// pwm_ctrl: period-aligned motor PWM generator with shadowed ratio/direction
// requests, one-cycle apply acknowledge and dead-time on direction reversal.
module pwm_ctrl #(
  parameter int unsigned CLK_DIV      = 4,
  parameter int unsigned DEAD_PERIODS = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       pwm_enable,
  input  logic       pwm_update,
  input  logic [7:0] pwm_ratio,
  input  logic       pwm_direction,
  output logic       pwm_done,
  output logic       pwm_out,
  output logic       pwm_dir_out,
  output logic [7:0] applied_ratio,
  output logic       dead_active
);

  localparam int unsigned        DIV_W     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0]   DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [3:0]         DEAD_INIT = 4'(DEAD_PERIODS);
  localparam logic [7:0]         CNT_LAST  = 8'd254;

  typedef enum logic [1:0] {IDLE, RUN, DEAD} state_e;

  state_e           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             pending_q, pending_d;
  logic [7:0]       pend_ratio_q, pend_ratio_d;
  logic             pend_dir_q, pend_dir_d;
  logic [3:0]       dead_cnt_q, dead_cnt_d;
  logic             done_q, done_d;
  logic             out_q, out_d;
  logic             dir_q, dir_d;
  logic [7:0]       ratio_q, ratio_d;
  logic             dead_q, dead_d;

  logic tick, boundary, apply;

  assign tick     = (state_q != IDLE) && (div_q == DIV_LAST);
  assign boundary = tick && (cnt_q == CNT_LAST);

  // Next-state: prescaler/counter, shadow capture, boundary-aligned apply and dead-time
  always_comb begin
    state_d      = state_q;
    div_d        = div_q;
    cnt_d        = cnt_q;
    pend_ratio_d = pend_ratio_q;
    pend_dir_d   = pend_dir_q;
    dead_cnt_d   = dead_cnt_q;
    out_d        = out_q;
    dir_d        = dir_q;
    ratio_d      = ratio_q;
    dead_d       = dead_q;
    done_d       = 1'b0;
    apply        = 1'b0;

    // A request arriving on a boundary edge is only captured; the boundary
    // below still works from the pre-edge pending values.
    if (pwm_update) begin
      pend_ratio_d = pwm_ratio;
      pend_dir_d   = pwm_direction;
    end

    case (state_q)
      IDLE: begin
        div_d      = '0;
        cnt_d      = '0;
        out_d      = 1'b0;
        dead_d     = 1'b0;
        dead_cnt_d = '0;
        if (pending_q)  apply   = 1'b1;
        if (pwm_enable) state_d = RUN;
      end
      default: begin
        if (!pwm_enable) begin
          state_d    = IDLE;
          div_d      = '0;
          cnt_d      = '0;
          out_d      = 1'b0;
          dead_d     = 1'b0;
          dead_cnt_d = '0;
        end else begin
          div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
          if (tick) cnt_d = (cnt_q == CNT_LAST) ? 8'd0 : cnt_q + 8'd1;
          out_d = (state_q == RUN) && (cnt_q < ratio_q);
          if (boundary) begin
            if (state_q == RUN) begin
              if (pending_q) begin
                if (pend_dir_q == dir_q || ratio_q == 8'd0 || DEAD_INIT == 4'd0) begin
                  apply = 1'b1;
                end else begin
                  state_d    = DEAD;
                  ratio_d    = 8'd0;
                  dead_d     = 1'b1;
                  dead_cnt_d = DEAD_INIT;
                end
              end
            end else begin
              // Dead-time always runs to completion, even if the pending
              // direction has since been changed back.
              if (dead_cnt_q <= 4'd1) begin
                apply      = 1'b1;
                state_d    = RUN;
                dead_d     = 1'b0;
                dead_cnt_d = '0;
              end else begin
                dead_cnt_d = dead_cnt_q - 4'd1;
              end
            end
          end
        end
      end
    endcase

    if (apply) begin
      ratio_d = pend_ratio_q;
      dir_d   = pend_dir_q;
      done_d  = 1'b1;
    end
    pending_d = pwm_update | (pending_q & ~apply);
  end

  // State and output registers, synchronous active-high reset
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      div_q        <= '0;
      cnt_q        <= '0;
      pending_q    <= 1'b0;
      pend_ratio_q <= '0;
      pend_dir_q   <= 1'b0;
      dead_cnt_q   <= '0;
      done_q       <= 1'b0;
      out_q        <= 1'b0;
      dir_q        <= 1'b0;
      ratio_q      <= '0;
      dead_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      div_q        <= div_d;
      cnt_q        <= cnt_d;
      pending_q    <= pending_d;
      pend_ratio_q <= pend_ratio_d;
      pend_dir_q   <= pend_dir_d;
      dead_cnt_q   <= dead_cnt_d;
      done_q       <= done_d;
      out_q        <= out_d;
      dir_q        <= dir_d;
      ratio_q      <= ratio_d;
      dead_q       <= dead_d;
    end
  end

  assign pwm_done      = done_q;
  assign pwm_out       = out_q;
  assign pwm_dir_out   = dir_q;
  assign applied_ratio = ratio_q;
  assign dead_active   = dead_q;

endmodule
